// File: rtl/dot_feeder_pkg.sv
// Shared types and helpers for the dot-product chunk feeder.
// Holds the feeder state enum, chunk-count ceiling and lane slice helpers.
package dot_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        PRESENT,
        DONE
    } state_t;

    // Number of U-lane chunks needed to cover N elements.
    function automatic int chunks_f(input int n, input int u);
        return (n + u - 1) / u;
    endfunction

    // LSB of lane k; lane 0 sits at the MSB end of the word.
    function automatic int lane_lsb_f(input int k, input int w, input int u);
        return w * (u - k - 1);
    endfunction

endpackage

// File: rtl/lane_mask_gen.sv
// Lane-enable mask for the tail chunk of a row/vector stream.
// Ports: c (chunk index), last (c is the final chunk), mask (1 = lane kept).
module lane_mask_gen
    import dot_feeder_pkg::*;
#(
    parameter int N  = 16,
    parameter int U  = 8,
    parameter int CW = 1
) (
    input  logic [CW-1:0] c,
    input  logic          last,
    output logic [U-1:0]  mask
);

    always_comb begin
        mask = '1;
        for (int k = 0; k < U; k++) begin
            if (last && (int'(c) * U + k >= N)) begin
                mask[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/dot_chunk_feeder.sv
// Streams one matrix row plus the shared vector, chunk by chunk, to the
// eight-lane dot-product controller; optional tail zero-pad under
// FEEDER_ZERO_PAD_EN.
// Ports: clk, reset (async, active-high), start/row_index (request),
// row_mem_* / vec_mem_* (memory read side, 1-cycle latency),
// first_row_plus_additional / vector2 / outsider_read_now / chunk_ready
// (consumer handshake), busy, done.
module dot_chunk_feeder
    import dot_feeder_pkg::*;
#(
    parameter int number_of_equations_per_cluster = 16,
    parameter int element_width                   = 32,
    parameter int no_of_units                     = 8,
    parameter int number_of_rows                  = 16,
    localparam int N      = number_of_equations_per_cluster,
    localparam int W      = element_width,
    localparam int U      = no_of_units,
    localparam int R      = number_of_rows,
    localparam int CHUNKS = chunks_f(N, U),
    localparam int DW     = W * U,
    localparam int RW     = $clog2(R),
    localparam int AW     = $clog2(R * CHUNKS),
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [RW-1:0] row_index,
    output logic          row_mem_rd_en,
    output logic [AW-1:0] row_mem_addr,
    input  logic [DW-1:0] row_mem_data,
    output logic [CW-1:0] vec_mem_addr,
    input  logic [DW-1:0] vec_mem_data,
    output logic [DW-1:0] first_row_plus_additional,
    output logic [DW-1:0] vector2,
    output logic          outsider_read_now,
    input  logic          chunk_ready,
    output logic          busy,
    output logic          done
);

    state_t        state;
    state_t        state_nx;
    logic [RW-1:0] row_q;
    logic [CW-1:0] c_q;
    logic          last;
    logic [DW-1:0] keep;

    assign last         = (c_q == CW'(CHUNKS - 1));
    assign row_mem_addr = AW'(row_q) * AW'(CHUNKS) + AW'(c_q);
    assign vec_mem_addr = c_q;

`ifdef FEEDER_ZERO_PAD_EN
    logic [U-1:0] mask;

    lane_mask_gen #(
        .N  (N),
        .U  (U),
        .CW (CW)
    ) u_mask (
        .c    (c_q),
        .last (last),
        .mask (mask)
    );

    always_comb begin
        keep = '0;
        for (int k = 0; k < U; k++) begin
            keep[lane_lsb_f(k, W, U) +: W] = {W{mask[k]}};
        end
    end
`else
    assign keep = '1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                     <= IDLE;
            row_q                     <= '0;
            c_q                       <= '0;
            first_row_plus_additional <= '0;
            vector2                   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                row_q <= row_index;
                c_q   <= '0;
            end
            if (state == PRESENT && chunk_ready && !last) begin
                c_q <= c_q + CW'(1);
            end
            if (state == LOAD) begin
                first_row_plus_additional <= row_mem_data & keep;
                vector2                   <= vec_mem_data & keep;
            end
        end
    end

    always_comb begin
        state_nx          = state;
        row_mem_rd_en     = 1'b0;
        outsider_read_now = 1'b0;
        busy              = 1'b0;
        done              = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = READ;
            end
            READ: begin
                row_mem_rd_en = 1'b1;
                busy          = 1'b1;
                state_nx      = LOAD;
            end
            LOAD: begin
                busy     = 1'b1;
                state_nx = PRESENT;
            end
            PRESENT: begin
                busy              = 1'b1;
                outsider_read_now = 1'b1;
                if (chunk_ready) state_nx = last ? DONE : READ;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dot_chunk_feeder.sv
// Self-checking bench for dot_chunk_feeder (N=12, U=8, W=32, R=16).
// Random and directed streams checked against a cycle-level reference model.
module tb_dot_chunk_feeder;

    localparam int TN = 12;
    localparam int TW = 32;
    localparam int TU = 8;
    localparam int TR = 16;
    localparam int CH = 2;
    localparam int DW = TW * TU;

`ifdef FEEDER_ZERO_PAD_EN
    localparam logic [DW-1:0] EXP_ONES = {{128{1'b1}}, {128{1'b0}}};
`else
    localparam logic [DW-1:0] EXP_ONES = {256{1'b1}};
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    row_index;
    logic          row_mem_rd_en;
    logic [4:0]    row_mem_addr;
    logic [DW-1:0] row_mem_data = '0;
    logic [0:0]    vec_mem_addr;
    logic [DW-1:0] vec_mem_data = '0;
    logic [DW-1:0] first_row_plus_additional;
    logic [DW-1:0] vector2;
    logic          outsider_read_now;
    logic          chunk_ready;
    logic          busy;
    logic          done;

    logic [DW-1:0] row_mem [TR*CH];
    logic [DW-1:0] vec_mem [CH];

    int n_chk  = 0;
    int n_fail = 0;
    int rlog[$];
    int vlog[$];

    dot_chunk_feeder #(
        .number_of_equations_per_cluster (TN),
        .element_width                   (TW),
        .no_of_units                     (TU),
        .number_of_rows                  (TR)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .start                     (start),
        .row_index                 (row_index),
        .row_mem_rd_en             (row_mem_rd_en),
        .row_mem_addr              (row_mem_addr),
        .row_mem_data              (row_mem_data),
        .vec_mem_addr              (vec_mem_addr),
        .vec_mem_data              (vec_mem_data),
        .first_row_plus_additional (first_row_plus_additional),
        .vector2                   (vector2),
        .outsider_read_now         (outsider_read_now),
        .chunk_ready               (chunk_ready),
        .busy                      (busy),
        .done                      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (row_mem_rd_en) begin
            row_mem_data <= row_mem[row_mem_addr];
            vec_mem_data <= vec_mem[vec_mem_addr];
        end
    end

    always @(negedge clk) begin
        if (!reset && row_mem_rd_en) begin
            rlog.push_back(int'(row_mem_addr));
            vlog.push_back(int'(vec_mem_addr));
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < TU; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic fill(input bit ones);
        for (int i = 0; i < TR*CH; i++) row_mem[i] = ones ? '1 : rand_word();
        for (int i = 0; i < CH; i++) vec_mem[i] = ones ? '1 : rand_word();
    endtask

    // Reference chunk: element c*U+k of row r / vector, zero past N if padded.
    function automatic logic [DW-1:0] exp_chunk(input bit is_vec,
                                                input int r, input int c);
        logic [DW-1:0] w;
        w = is_vec ? vec_mem[c] : row_mem[r*CH + c];
`ifdef FEEDER_ZERO_PAD_EN
        for (int k = 0; k < TU; k++) begin
            if (c*TU + k >= TN) w[TW*(TU-k)-1 -: TW] = '0;
        end
`endif
        return w;
    endfunction

    // Reference model: per-stream timeline in negedge-sampled cycles.
    int            cyc       = 0;
    bit            m_active  = 0;
    int            m_row     = 0;
    int            m_c       = 0;
    int            m_rd_at   = -10;
    int            m_done_at = -10;
    logic [DW-1:0] m_hr      = '0;
    logic [DW-1:0] m_hv      = '0;

    always @(negedge clk) begin
        bit e_rd;
        bit e_valid;
        bit e_done;
        if (reset) begin
            m_active  = 0;
            m_done_at = -10;
            m_hr      = '0;
            m_hv      = '0;
            chk("rst_busy", DW'(busy), '0);
            chk("rst_valid", DW'(outsider_read_now), '0);
            chk("rst_rd_en", DW'(row_mem_rd_en), '0);
        end else begin
            e_rd    = m_active && cyc == m_rd_at;
            e_valid = m_active && cyc >= m_rd_at + 2;
            e_done  = cyc == m_done_at;
            if (e_valid) begin
                m_hr = exp_chunk(0, m_row, m_c);
                m_hv = exp_chunk(1, m_row, m_c);
            end
            chk("busy", DW'(busy), DW'(m_active));
            chk("rd_en", DW'(row_mem_rd_en), DW'(e_rd));
            chk("valid", DW'(outsider_read_now), DW'(e_valid));
            chk("done", DW'(done), DW'(e_done));
            if (e_rd) begin
                chk("row_addr", DW'(row_mem_addr), DW'(m_row*CH + m_c));
                chk("vec_addr", DW'(vec_mem_addr), DW'(m_c));
            end
            chk("row_data", first_row_plus_additional, m_hr);
            chk("vec_data", vector2, m_hv);
            if (e_valid && chunk_ready) begin
                if (m_c == CH - 1) begin
                    m_active  = 0;
                    m_done_at = cyc + 1;
                end else begin
                    m_c++;
                    m_rd_at = cyc + 1;
                end
            end else if (!m_active && !e_done && start) begin
                m_active = 1;
                m_row    = int'(row_index);
                m_c      = 0;
                m_rd_at  = cyc + 1;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n = edges from the start drive up to the one after which done shows.
    task automatic run_row(input int row, input bit glitch, output int n);
        row_index = 4'(row);
        start     = 1'b1;
        n         = 0;
        do begin
            tick();
            start = 1'b0;
            n++;
            if (glitch && n == 2) begin
                start     = 1'b1;
                row_index = 4'(row) ^ 4'h4;
            end
        end while (!done && n < 60);
    endtask

    task automatic wait_valid();
        int j = 0;
        while (!outsider_read_now && j < 20) begin
            tick();
            j++;
        end
        chk("valid_timeout", DW'(outsider_read_now), DW'(1));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_rd_en"}, DW'(row_mem_rd_en), '0);
        chk({nm, "_raddr"}, DW'(row_mem_addr), '0);
        chk({nm, "_vaddr"}, DW'(vec_mem_addr), '0);
        chk({nm, "_rdata"}, first_row_plus_additional, '0);
        chk({nm, "_vdata"}, vector2, '0);
        chk({nm, "_valid"}, DW'(outsider_read_now), '0);
        chk({nm, "_busy"}, DW'(busy), '0);
        chk({nm, "_done"}, DW'(done), '0);
    endtask

    initial begin
        int n;
        logic [DW-1:0] hr;
        logic [DW-1:0] hv;
        reset       = 1'b1;
        start       = 1'b0;
        chunk_ready = 1'b0;
        row_index   = '0;
        fill(0);
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Row 3, consumer always ready: addresses 6,7 and 7-cycle latency.
        chunk_ready = 1'b1;
        rlog.delete();
        vlog.delete();
        run_row(3, 0, n);
        chk("latency", DW'(n), DW'(7));
        chk("nreads", DW'(rlog.size()), DW'(2));
        if (rlog.size() == 2) begin
            chk("raddr0", DW'(rlog[0]), DW'(6));
            chk("raddr1", DW'(rlog[1]), DW'(7));
            chk("vaddr0", DW'(vlog[0]), DW'(0));
            chk("vaddr1", DW'(vlog[1]), DW'(1));
        end
        tick();

        // All-ones memories: tail chunk lanes 4..7 depend on padding.
        fill(1);
        run_row(5, 0, n);
        chk("ones_row", first_row_plus_additional, EXP_ONES);
        chk("ones_vec", vector2, EXP_ONES);
        tick();

        // Five-cycle stall in PRESENT, then read issued right after accept.
        fill(0);
        chunk_ready = 1'b0;
        row_index   = 4'd9;
        start       = 1'b1;
        tick();
        start = 1'b0;
        wait_valid();
        hr = first_row_plus_additional;
        hv = vector2;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", DW'(outsider_read_now), DW'(1));
            chk("stall_row", first_row_plus_additional, hr);
            chk("stall_vec", vector2, hv);
        end
        chunk_ready = 1'b1;
        tick();
        chk("read_after_accept", DW'(row_mem_rd_en), DW'(1));
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("stall_done", DW'(done), DW'(1));
        tick();

        // Reset in PRESENT of chunk 0, then a fresh stream starts at chunk 0.
        chunk_ready = 1'b0;
        row_index   = 4'd2;
        start       = 1'b1;
        tick();
        start = 1'b0;
        wait_valid();
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("midrst");
        tick();
        #2;
        reset = 1'b0;
        tick();
        chunk_ready = 1'b1;
        rlog.delete();
        run_row(2, 0, n);
        chk("rst_restart_latency", DW'(n), DW'(7));
        chk("rst_restart_addr", DW'(rlog.size() > 0 ? rlog[0] : -1), DW'(4));
        tick();

        // Start pulsed while busy is ignored.
        rlog.delete();
        run_row(3, 1, n);
        chk("glitch_latency", DW'(n), DW'(7));
        chk("glitch_nreads", DW'(rlog.size()), DW'(2));
        if (rlog.size() == 2) begin
            chk("glitch_raddr0", DW'(rlog[0]), DW'(6));
            chk("glitch_raddr1", DW'(rlog[1]), DW'(7));
        end
        tick();

        // Random streams with random backpressure and stray starts.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) fill(0);
            row_index   = 4'($urandom_range(0, TR - 1));
            chunk_ready = 1'($urandom_range(0, 1));
            start       = 1'b1;
            n = 0;
            while (n < 200) begin
                tick();
                n++;
                if (done) break;
                start       = ($urandom_range(0, 7) == 0);
                row_index   = 4'($urandom_range(0, TR - 1));
                chunk_ready = 1'($urandom_range(0, 1));
            end
            start = 1'b0;
            chk("rand_done", DW'(done), DW'(1));
            repeat ($urandom_range(0, 2)) tick();
        end

        chunk_ready = 1'b0;
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_chunk_feeder.md
# dot_chunk_feeder

Streams one matrix row and the shared vector, chunk by chunk, into the eight-lane dot-product controller. It is the transmitting end of the `first_row_plus_additional` / `vector2` / `outsider_read_now` interface. It reads `no_of_units`-wide words from the row and vector memories and zero-pads the tail chunk. It raises `done` once the last chunk has been accepted.

## Interface
- `number_of_equations_per_cluster`, 16: elements per row and per vector (N)
- `element_width`, 32: bits per element (W)
- `no_of_units`, 8: lanes per chunk (U)
- `number_of_rows`, 16: rows held in the row memory (R)
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  one-cycle pulse; begins streaming row `row_index`
- `row_index`  in  $clog2(R)  row to stream; sampled when `start` is accepted
- `row_mem_rd_en`  out  1  row memory read strobe
- `row_mem_addr`  out  $clog2(R*CHUNKS)  row memory word address
- `row_mem_data`  in  W*U  row memory read data; valid one cycle after `row_mem_rd_en`
- `vec_mem_addr`  out  $clog2(CHUNKS)  vector memory word address; read on the same strobe
- `vec_mem_data`  in  W*U  vector memory read data; same latency as row data
- `first_row_plus_additional`  out  W*U  row chunk presented to the consumer
- `vector2`  out  W*U  vector chunk presented to the consumer
- `outsider_read_now`  out  1  chunk valid
- `chunk_ready`  in  1  consumer accepts the chunk when this and `outsider_read_now` are both high
- `busy`  out  1  high from `start` acceptance until `done`
- `done`  out  1  one-cycle pulse after the last chunk is accepted

## Operation
- CHUNKS = ceil(N/U). For N=16, U=8, CHUNKS=2. For N=12, CHUNKS=2.
- Lane k of a chunk occupies bits [W*(U-k)-1 : W*(U-k-1)], so element 0 sits at the MSB end.
- Chunk c of row r is at `row_mem_addr` = r*CHUNKS + c. The vector chunk is at `vec_mem_addr` = c.
- States and transitions:
  - IDLE: `start` latches `row_index`, clears chunk counter c to 0, goes to READ.
  - READ: `row_mem_rd_en`=1 with both addresses driven, goes to LOAD.
  - LOAD: captures both memory data words into the output registers, with lane masking applied; goes to PRESENT.
  - PRESENT: holds `outsider_read_now`=1. On `chunk_ready`, the chunk is accepted. If c==CHUNKS-1, go to DONE. Otherwise increment c and go to READ.
  - DONE: `done`=1 for one cycle, then IDLE.
- `start` is ignored whenever the state is not IDLE.
- Output data registers hold their values in all states except LOAD. They are not cleared at `done`.
- Only `reset` aborts a stream. There is no abort input.

## Timing
- Reset (asynchronous, immediate): state IDLE, c=0, and all outputs 0. This covers `row_mem_rd_en`, both addresses, both data buses, `outsider_read_now`, `busy` and `done`.
- `start` is sampled at edge T. Then:
  - `busy`=1 and `row_mem_rd_en`=1 after edge T.
  - Data is captured at edge T+2.
  - `outsider_read_now`=1 after edge T+2.
- With `chunk_ready` held at 1, each chunk costs 3 cycles. Rows take 3*CHUNKS+1 cycles from `start` to `done`.
- `chunk_ready` low stalls indefinitely in PRESENT, with data stable.
- `chunk_ready` high outside PRESENT has no effect.
- `busy` falls in the same cycle that `done` pulses.
- Reset asserted mid-stream drops `outsider_read_now` asynchronously. The consumer sees no further chunks.

## Configuration
- `FEEDER_ZERO_PAD_EN` defined:
  - In the last chunk, lanes k with c*U+k ≥ N are forced to 0 on both `first_row_plus_additional` and `vector2`.
  - When N%U==0, no lanes are masked.
- `FEEDER_ZERO_PAD_EN` undefined: memory data passes unmasked. The memories must then be pre-padded with zeros.

## Structure
- Shared package `dot_feeder_pkg` holds:
  - the state enum (IDLE, READ, LOAD, PRESENT, DONE)
  - the `chunks_f(N,U)` ceiling function
  - the lane-index-to-bit-slice constant function
- Sub-module `lane_mask_gen`:
  - Inputs: c and `last`.
  - Output: a U-bit lane-enable mask, all ones unless `last` is set and padding is needed.
  - Instantiated only under `FEEDER_ZERO_PAD_EN`.

## Test plan
- N=16, U=8, `row_index`=3, `chunk_ready` tied to 1:
  - reads addresses 6 and 7
  - two chunks presented, `outsider_read_now` high 1 cycle each
  - `done` 7 cycles after `start`
- N=12, U=8, `FEEDER_ZERO_PAD_EN` defined, memories filled with 0xFFFFFFFF: second chunk has lanes 0–3 = 0xFFFFFFFF and lanes 4–7 = 0.
- Same N=12 stimulus with `FEEDER_ZERO_PAD_EN` undefined: all eight lanes of the second chunk = 0xFFFFFFFF.
- `chunk_ready` held low for 5 cycles in PRESENT:
  - `outsider_read_now` and both data buses stay stable
  - the next read is issued the cycle after acceptance
- Reset asserted mid-PRESENT of chunk 0: all outputs 0 immediately, and a later `start` streams from chunk 0.
- `start` pulsed while `busy`: ignored, and address sequence and `done` timing are unchanged.
